// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD   = 4;
  localparam int WORD_BYTES_SHIFT = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_ready_o pulses with the 4th byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  r_idx;
  // Only the first three bytes need storage; the fourth is merged combinationally
  // so the completed word is available on the same edge that accepts it.
  logic [23:0] r_shift;

  assign word_o       = {r_shift, byte_data_i};
  assign word_ready_o = byte_en_i && (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (clr_i) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (byte_en_i) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= word_o[23:0];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills instruction memory from a byte stream and holds the CPU in reset until done.
// Optional build macro LOADER_CHECKSUM_EN adds checksum_o (sum of written words).
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             cpu_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_count_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum_o
`endif
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_word_count;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;

  logic             w_start_acc;
  logic             w_byte_fire;
  logic             w_word_ready;
  logic [31:0]      w_word;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_count_inc;
  logic [31:0]      w_addr;

  assign w_start_acc  = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_byte_fire  = byte_valid_i && (r_state == LOAD);
  assign w_len_eff    = (len_i > CNT_W'(DEPTH_WORDS)) ? CNT_W'(DEPTH_WORDS) : len_i;
  assign w_count_inc  = r_word_count + 1'b1;
  assign w_addr       = BASE_ADDR + (32'(r_word_count) << WORD_BYTES_SHIFT);
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign word_count_o = r_word_count;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (w_start_acc),
    .byte_en_i    (w_byte_fire),
    .byte_data_i  (byte_data_i),
    .word_o       (w_word),
    .word_ready_o (w_word_ready)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    byte_ready_o = 1'b0;
    wr_en_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    cpu_rst_o    = 1'b1;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_next = (w_len_eff == '0) ? DONE : LOAD;
      end
      LOAD: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (w_word_ready) w_state_next = WRITE;
      end
      WRITE: begin
        wr_en_o      = 1'b1;
        busy_o       = 1'b1;
        w_state_next = (w_count_inc == r_len) ? DONE : LOAD;
      end
      DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
        if (start_i) w_state_next = (w_len_eff == '0) ? DONE : LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address and data are captured as the 4th byte lands, so they are stable
  // throughout WRITE and hold their value afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len        <= '0;
      r_word_count <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      if (w_start_acc) begin
        r_len        <= w_len_eff;
        r_word_count <= '0;
      end
      if (w_word_ready) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_word;
      end
      if (r_state == WRITE) r_word_count <= w_count_inc;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  r_checksum <= '0;
    else if (w_start_acc)       r_checksum <= '0;
    else if (r_state == WRITE)  r_checksum <= r_checksum + r_wr_data;
  end

  assign checksum_o = r_checksum;
`endif

endmodule
